// File: rtl/mips_rf_writeback_arbiter.sv
// Merges the non-stallable ALU writeback (A) with buffered long-latency results (B)
// onto the register file's single write port, and tracks pending B writes for hazards.
module mips_rf_writeback_arbiter #(
    parameter int Data_Width   = 32,
    parameter int Addr_Width   = 5,
    parameter int FIFO_Depth   = 4,
    parameter int Starve_Limit = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          a_valid,
    input  logic [Addr_Width-1:0]         a_addr,
    input  logic [Data_Width-1:0]         a_data,
    input  logic                          b_valid,
    output logic                          b_ready,
    input  logic [Addr_Width-1:0]         b_addr,
    input  logic [Data_Width-1:0]         b_data,
    input  logic [Addr_Width-1:0]         q_addr,
    output logic                          q_hit,
    output logic [$clog2(FIFO_Depth):0]   pend_cnt,
    output logic                          stall_req,
    output logic                          wen,
    output logic [Addr_Width-1:0]         WA,
    output logic [Data_Width-1:0]         WD
);

    localparam int PW = $clog2(FIFO_Depth);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(Starve_Limit + 1);

    // Handshake: a B transfer happens on a rising edge where b_valid && b_ready;
    // b_ready depends only on the registered occupancy, never on this cycle's pop.

    logic [Addr_Width-1:0] addr_mem [FIFO_Depth];
    logic [Data_Width-1:0] data_mem [FIFO_Depth];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         cnt;
    logic [SW-1:0]         starve;
    logic                  full, empty, push, pop;
    logic                  grant_valid;
    logic [Addr_Width-1:0] grant_addr;
    logic [Data_Width-1:0] grant_data;
    logic                  hit;
    logic [PW-1:0]         offset;

    assign full     = (cnt == CW'(FIFO_Depth));
    assign empty    = (cnt == '0);
    assign b_ready  = !rst && !full;
    assign push     = b_valid && b_ready;
    assign pop      = !a_valid && !empty;
    assign pend_cnt = cnt;

    always_comb begin
        grant_valid = 1'b0;
        grant_addr  = '0;
        grant_data  = '0;
        if (a_valid) begin
            grant_valid = 1'b1;
            grant_addr  = a_addr;
            grant_data  = a_data;
        end else if (pop) begin
            grant_valid = 1'b1;
            grant_addr  = addr_mem[rd_ptr];
            grant_data  = data_mem[rd_ptr];
        end
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        hit    = 1'b0;
        offset = '0;
        for (int i = 0; i < FIFO_Depth; i++) begin
            offset = PW'(i) - rd_ptr;
            if ((CW'(offset) < cnt) && (addr_mem[i] == q_addr)) hit = 1'b1;
        end
        q_hit = hit && (q_addr != '0);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= b_addr;
            data_mem[wr_ptr] <= b_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve    <= '0;
            stall_req <= 1'b0;
        end else begin
            if (empty || pop)
                starve <= '0;
            else if (starve != SW'(Starve_Limit))
                starve <= starve + 1'b1;
            stall_req <= (starve == SW'(Starve_Limit));
        end
    end

    // Writes to r0 are consumed but suppressed; WA/WD keep the last real write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen <= 1'b0;
            WA  <= '0;
            WD  <= '0;
        end else begin
            wen <= grant_valid && (grant_addr != '0);
            if (grant_valid && (grant_addr != '0)) begin
                WA <= grant_addr;
                WD <= grant_data;
            end
        end
    end

endmodule

// File: tb/tb_mips_rf_writeback_arbiter.sv
// Randomized and directed bench for mips_rf_writeback_arbiter, checked each cycle
// against a queue-based behavioural model and an expected-write scoreboard.
module tb_mips_rf_writeback_arbiter;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid, b_valid, b_ready, q_hit, stall_req, wen;
    logic [AW-1:0] a_addr, b_addr, q_addr, WA;
    logic [DW-1:0] a_data, b_data, WD;
    logic [$clog2(DEPTH):0] pend_cnt;

    always #5 clk = ~clk;

    mips_rf_writeback_arbiter #(
        .Data_Width(DW), .Addr_Width(AW), .FIFO_Depth(DEPTH), .Starve_Limit(LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .q_addr(q_addr), .q_hit(q_hit), .pend_cnt(pend_cnt), .stall_req(stall_req),
        .wen(wen), .WA(WA), .WD(WD)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending B entries as a plain queue, writes as a scoreboard.
    logic [AW+DW-1:0] model_q[$];
    logic [AW+DW-1:0] exp_q[$];
    int               starve;
    bit               exp_wen, exp_stall, wa_known;
    logic [AW-1:0]    exp_wa;
    logic [DW-1:0]    exp_wd;

    task automatic model_reset();
        model_q.delete();
        exp_q.delete();
        starve    = 0;
        exp_wen   = 0;
        exp_stall = 0;
        wa_known  = 1;
        exp_wa    = '0;
        exp_wd    = '0;
    endtask

    task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                         input logic [AW-1:0] qa);
        bit               exp_hit, accept, g;
        logic [AW-1:0]    ga;
        logic [DW-1:0]    gd;
        logic [AW+DW-1:0] e;
        @(negedge clk);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        q_addr  = qa;
        #1;
        check("b_ready", b_ready, model_q.size() < DEPTH);
        exp_hit = 0;
        foreach (model_q[i]) if (qa != '0 && model_q[i][AW+DW-1:DW] == qa) exp_hit = 1;
        check("q_hit", q_hit, exp_hit);

        accept    = bv && (model_q.size() < DEPTH);
        exp_stall = (starve == LIMIT);
        ga = '0; gd = '0;
        if (av) begin
            g = 1; ga = aa; gd = ad;
            if (model_q.size() > 0) starve = (starve + 1 > LIMIT) ? LIMIT : starve + 1;
            else starve = 0;
        end else if (model_q.size() > 0) begin
            e = model_q.pop_front();
            g = 1; ga = e[AW+DW-1:DW]; gd = e[DW-1:0];
            starve = 0;
        end else begin
            g = 0;
            starve = 0;
        end
        exp_wen = g && (ga != '0);
        if (exp_wen) begin
            exp_wa = ga; exp_wd = gd; wa_known = 1;
            exp_q.push_back({ga, gd});
        end else if (g) begin
            wa_known = 0;
        end
        if (accept) model_q.push_back({ba, bd});

        @(posedge clk);
        #1;
        check("wen", wen, exp_wen);
        if (wen) begin
            if (exp_q.size() > 0) check("write_seq", {WA, WD}, exp_q.pop_front());
            else check("spurious_write", wen, 1'b0);
        end
        if (wa_known) begin
            check("WA", WA, exp_wa);
            check("WD", WD, exp_wd);
        end
        check("pend_cnt", pend_cnt, model_q.size());
        check("stall_req", stall_req, exp_stall);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0;
        #1;
        check("rst_wen", wen, 1'b0);
        check("rst_pend_cnt", pend_cnt, 0);
        check("rst_stall_req", stall_req, 1'b0);
        check("rst_b_ready", b_ready, 1'b0);
        check("rst_WA", WA, 0);
        check("rst_WD", WD, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, '0, '0, 0, '0, '0, '0);
    endtask

    initial begin
        rst = 1'b1;
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0; q_addr = '0;
        model_reset();
        do_reset();

        // A-only writes, including a suppressed write to r0
        drive(1, 5'd5, 32'h1234, 0, '0, '0, '0);
        drive(1, 5'd0, 32'hdead, 0, '0, '0, '0);
        idle(2);

        // Fill the FIFO under constant A traffic, then a held-off fifth offer
        for (int r = 8; r < 12; r++)
            drive(1, 5'(r + 12), $urandom, 1, 5'(r), $urandom, 5'd9);
        drive(1, 5'd3, $urandom, 1, 5'd12, $urandom, 5'd9);
        drive(0, '0, '0, 0, '0, '0, 5'd9);
        drive(0, '0, '0, 0, '0, '0, 5'd9);
        drive(0, '0, '0, 1, 5'd13, $urandom, 5'd9);
        idle(4);

        // Starvation: one entry pinned behind continuous A traffic
        drive(1, 5'd1, $urandom, 1, 5'd7, $urandom, 5'd7);
        for (int i = 0; i < 10; i++) drive(1, 5'd2, $urandom, 0, '0, '0, 5'd7);
        idle(3);

        // Reset with three entries pending
        for (int i = 0; i < 3; i++) drive(1, 5'd4, $urandom, 1, 5'(16 + i), $urandom, '0);
        do_reset();
        idle(3);

        // Random traffic with a small address range so hazards and wrap occur often
        for (int i = 0; i < 300; i++)
            drive($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)));
        idle(DEPTH + 2);
        check("exp_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
